rmux_ord: RTL
=============

# rmux_ord

Read-path router between the on-chip feature RAM (source 0) and the SDRAM picture port (source 1) in the CONV read path. It steers each address burst to one memory and records the choice in a tag FIFO. Returned data bursts are then accepted strictly in issue order from the memory that owns the oldest outstanding burst, with no reliance on valid priority. Data is lane-masked by channel count, and 16-bit RGB565 pixel words are expanded into byte lanes. Both output streams leave through registered slices.

## Interface
- DW, 8, bits per lane
- DN, 8, lane count (power of two, ≥4)
- DW0, 16, SDRAM pixel word width (RGB565)
- AW, 13, address width
- CW, $clog2(DN), channel-count field width
- IFW, CW+2, info width
- TD, 4, tag FIFO depth (outstanding bursts, power of two)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous and active-low
- info  in  IFW  [CW+1]=ram_sel, [CW]=mem_sel (0 RAM, 1 SDRAM), [CW-1:0]=channel count
- m_addr / m_addr_first / m_addr_last / m_addr_valid  in  AW/1/1/1  address burst in
- m_addr_ready  out  1
- s_ram_sel  out  1  ram_sel registered with RAM address beat
- s_addr0, s_addr_first0, s_addr_last0, s_addr_valid0  out  AW/1/1/1  to RAM; s_addr_ready0 in 1
- s_addr1, s_addr_first1, s_addr_last1, s_addr_valid1  out  AW/1/1/1  to SDRAM; s_addr_ready1 in 1
- m_data0 / m_data_first0 / m_data_last0 / m_data_valid0  in  DN*DW/1/1/1; m_data_ready0 out 1
- m_data1 / m_data_first1 / m_data_last1 / m_data_valid1  in  DW0/1/1/1; m_data_ready1 out 1
- s_data / s_data_first / s_data_last / s_data_valid  out  DN*DW/1/1/1; s_data_ready in 1
- outstanding  out  $clog2(TD)+1  tag FIFO occupancy

## Operation
- Address side: info sampled on accepted beat with m_addr_first; {mem_sel, ram_sel, channel} latched and held until beat with m_addr_last accepted (info ignored mid-burst). Single-beat burst (first&last) uses current info.
- On accepted first beat, push {mem_sel, channel} into tag FIFO. m_addr_ready=0 on a first beat while FIFO full; mid-burst beats never blocked by FIFO.
- Address register slice per destination, one entry. m_addr_ready = dest slice empty or dest ready (plus FIFO rule). Non-selected side untouched.
- Data side: tag FIFO head selects source. Head mem_sel=0: m_data_ready0=slice-can-accept, m_data_ready1=0; mem_sel=1 the reverse. FIFO empty: both readies 0; data valid on either source waits.
- Pop tag on accepted data beat with last from owning source.
- Pixel expansion (source 1): lane2=R{5}, lane1=G{6}, lane0=B{5}, MSB-aligned in DW, low bits per Configuration; lanes 3..DN-1 zero.
- Channel mask (head tag channel c): c=0 → all lanes pass; c=k → lanes 0..k-1 pass, rest zero. Applied to both sources.
- Output data slice: 2-entry skid buffer, full throughput, ready to source registered (not combinational from s_data_ready).

## Timing
- Reset: all s_*valid=0, s_ram_sel=0, s_addr*=0, s_data*=0, tag FIFO empty, outstanding=0, latched info=0; m_addr_ready and m_data_ready* = 0 during reset, then follow rules.
- Latency: address 1 cycle input→s_addr*; data 1 cycle input→s_data when slice empty.
- Tag push visible to data side next cycle (no same-cycle bypass).
- Simultaneous push and pop: occupancy unchanged; full test uses pre-pop occupancy (push refused when full even if popping).
- Valid held until ready on every output; payload stable while valid&~ready.
- Data last without owning tag cannot be accepted (ready 0); bench must never see s_data from non-owning source.

## Configuration
- RMUX_RGB_REPLICATE_EN defined: pixel low bits filled by replicating component MSBs (R5→{R,R[4:2]} for DW=8, G6→{G,G[5:4]}); 5'h1F→8'hFF.
- Undefined: low bits zero (5'h1F→8'hF8, 6'h3F→8'hFC).

## Test plan
- RAM burst, info={ram_sel=1,mem_sel=0,ch=0}, 4 addr beats 0x010–0x013 → s_addr0 same values, s_ram_sel=1, 1-cycle latency; 4 data beats pass unmasked, outstanding 1→0 after last.
- SDRAM pixel 16'hF81F, ch=3, no macro → s_data low 24 bits 0xF800F8, upper lanes 0; with macro → 0xFF00FF.
- Channel mask: RAM data all-0xAA, ch=2 → s_data=0x...0000AAAA (lanes 0–1 only).
- Ordering: issue SDRAM burst then RAM burst; RAM data valid first → m_data_ready0=0 until SDRAM last accepted, then RAM data forwarded.
- Full: TD=4 bursts outstanding, 5th first beat → m_addr_ready=0; pop one in same cycle → still refused that cycle, accepted next.
- Backpressure/reset: s_data_ready=0 for 3 cycles → s_data stable, no beat lost; rst_n low mid-burst → all valids 0 and outstanding=0 asynchronously.

Source files
------------

// File: rtl/rmux_ord.sv
// Read-path router: steers address bursts to RAM (0) or SDRAM (1) and returns data strictly in issue order.
// Define RMUX_RGB_REPLICATE_EN to fill expanded RGB565 low bits by MSB replication instead of zeros.
module rmux_ord #(
    parameter int DW  = 8,
    parameter int DN  = 8,
    parameter int DW0 = 16,
    parameter int AW  = 13,
    parameter int CW  = $clog2(DN),
    parameter int IFW = CW + 2,
    parameter int TD  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IFW-1:0]        info,
    input  logic [AW-1:0]         m_addr,
    input  logic                  m_addr_first,
    input  logic                  m_addr_last,
    input  logic                  m_addr_valid,
    output logic                  m_addr_ready,
    output logic                  s_ram_sel,
    output logic [AW-1:0]         s_addr0,
    output logic                  s_addr_first0,
    output logic                  s_addr_last0,
    output logic                  s_addr_valid0,
    input  logic                  s_addr_ready0,
    output logic [AW-1:0]         s_addr1,
    output logic                  s_addr_first1,
    output logic                  s_addr_last1,
    output logic                  s_addr_valid1,
    input  logic                  s_addr_ready1,
    input  logic [DN*DW-1:0]      m_data0,
    input  logic                  m_data_first0,
    input  logic                  m_data_last0,
    input  logic                  m_data_valid0,
    output logic                  m_data_ready0,
    input  logic [DW0-1:0]        m_data1,
    input  logic                  m_data_first1,
    input  logic                  m_data_last1,
    input  logic                  m_data_valid1,
    output logic                  m_data_ready1,
    output logic [DN*DW-1:0]      s_data,
    output logic                  s_data_first,
    output logic                  s_data_last,
    output logic                  s_data_valid,
    input  logic                  s_data_ready,
    output logic [$clog2(TD):0]   outstanding
);

    localparam int PW = $clog2(TD);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(TD);

    logic          lat_mem, lat_ram;
    logic          eff_mem, eff_ram, dest_can, addr_fire, push, pop, tag_full, tag_empty;
    logic [CW:0]   tag_mem [TD];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          head_mem;
    logic [CW-1:0] head_ch;
    logic          in_ready, sel_valid, in_fire, in_first, in_last;
    logic [DN*DW-1:0] pix, raw, in_data;
    logic [DN*DW-1:0] skid_data;
    logic          skid_first, skid_last, skid_valid;

    // Mid-burst beats follow the selection captured on the first beat.
    assign eff_mem   = m_addr_first ? info[CW]   : lat_mem;
    assign eff_ram   = m_addr_first ? info[CW+1] : lat_ram;
    assign tag_full  = (count == FULL_CNT);
    assign tag_empty = (count == '0);
    assign dest_can  = eff_mem ? (~s_addr_valid1 | s_addr_ready1) : (~s_addr_valid0 | s_addr_ready0);
    assign m_addr_ready = rst_n & dest_can & ~(m_addr_first & tag_full);
    assign addr_fire = m_addr_valid & m_addr_ready;
    assign push      = addr_fire & m_addr_first;
    assign outstanding = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_mem <= 1'b0;
            lat_ram <= 1'b0;
        end else if (push) begin
            lat_mem <= info[CW];
            lat_ram <= info[CW+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_addr0 <= '0; s_addr_first0 <= 1'b0; s_addr_last0 <= 1'b0; s_addr_valid0 <= 1'b0;
            s_addr1 <= '0; s_addr_first1 <= 1'b0; s_addr_last1 <= 1'b0; s_addr_valid1 <= 1'b0;
            s_ram_sel <= 1'b0;
        end else begin
            if (addr_fire && !eff_mem) begin
                s_addr0 <= m_addr; s_addr_first0 <= m_addr_first; s_addr_last0 <= m_addr_last;
                s_addr_valid0 <= 1'b1;
                s_ram_sel <= eff_ram;
            end else if (s_addr_ready0) begin
                s_addr_valid0 <= 1'b0;
            end
            if (addr_fire && eff_mem) begin
                s_addr1 <= m_addr; s_addr_first1 <= m_addr_first; s_addr_last1 <= m_addr_last;
                s_addr_valid1 <= 1'b1;
            end else if (s_addr_ready1) begin
                s_addr_valid1 <= 1'b0;
            end
        end
    end

    // Tag storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= {info[CW], info[CW-1:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign head_mem  = tag_mem[rd_ptr][CW];
    assign head_ch   = tag_mem[rd_ptr][CW-1:0];
    assign in_ready  = ~skid_valid;
    assign m_data_ready0 = ~tag_empty & ~head_mem & in_ready;
    assign m_data_ready1 = ~tag_empty &  head_mem & in_ready;
    assign sel_valid = head_mem ? m_data_valid1 : m_data_valid0;
    assign in_first  = head_mem ? m_data_first1 : m_data_first0;
    assign in_last   = head_mem ? m_data_last1  : m_data_last0;
    assign in_fire   = sel_valid & ~tag_empty & in_ready;
    assign pop       = in_fire & in_last;

    function automatic logic [DW-1:0] expand(input logic [5:0] v, input int n);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW; i++) begin
`ifdef RMUX_RGB_REPLICATE_EN
            r[DW-1-i] = v[n-1-(i%n)];
`else
            if (i < n) r[DW-1-i] = v[n-1-i];
`endif
        end
        return r;
    endfunction

    // RGB565 unpacks to lanes 2/1/0; the head tag's channel count then masks off unused lanes.
    always_comb begin
        pix = '0;
        pix[2*DW +: DW] = expand({1'b0, m_data1[15:11]}, 5);
        pix[DW   +: DW] = expand(m_data1[10:5], 6);
        pix[0    +: DW] = expand({1'b0, m_data1[4:0]}, 5);
        raw = head_mem ? pix : m_data0;
        in_data = '0;
        for (int l = 0; l < DN; l++) begin
            if (head_ch == '0 || CW'(l) < head_ch) in_data[l*DW +: DW] = raw[l*DW +: DW];
        end
    end

    // Two-entry skid: the output register refills from the skid entry first so order is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_data <= '0; s_data_first <= 1'b0; s_data_last <= 1'b0; s_data_valid <= 1'b0;
            skid_data <= '0; skid_first <= 1'b0; skid_last <= 1'b0; skid_valid <= 1'b0;
        end else if (!s_data_valid || s_data_ready) begin
            if (skid_valid) begin
                s_data <= skid_data; s_data_first <= skid_first; s_data_last <= skid_last;
                s_data_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                s_data <= in_data; s_data_first <= in_first; s_data_last <= in_last;
                s_data_valid <= 1'b1;
            end else begin
                s_data_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_data <= in_data; skid_first <= in_first; skid_last <= in_last;
            skid_valid <= 1'b1;
        end
    end

endmodule
